idma_obi_sram_bridge: RTL and testbench
=======================================

IDMA_OBI_SRAM_BRIDGE -- requirements
Module: idma_obi_sram_bridge

Interface
REQ-001 SHALL have parameter DataWidth, default 32, OBI/SRAM data width in bits (multiple of 8).
REQ-002 SHALL have parameter AddrWidth, default 32, OBI byte-address width.
REQ-003 SHALL have parameter IdWidth, default 1, OBI aid/rid width.
REQ-004 SHALL have parameter NumWords, default 1024, SRAM depth in words (>= 2).
REQ-005 SHALL have parameter RspDepth, default 2, response FIFO depth and outstanding-transaction limit (>= 1).
REQ-006 SHALL use one clock and an asynchronous, active-high reset: clk_i and rst_i.
REQ-007 Ports, as name direction width meaning:
- clk_i in 1 clock
- rst_i in 1 async active-high reset
- obi_req_i in 1 A-channel request
- obi_addr_i in AddrWidth byte address
- obi_we_i in 1 write enable
- obi_be_i in DataWidth/8 byte enables
- obi_wdata_i in DataWidth write data
- obi_aid_i in IdWidth request id
- obi_gnt_o out 1 A-channel grant
- obi_rvalid_o out 1 R-channel valid
- obi_rready_i in 1 R-channel ready
- obi_rdata_o out DataWidth read data
- obi_rid_o out IdWidth response id
- obi_err_o out 1 response error
- sram_req_o out 1 SRAM access strobe
- sram_we_o out 1 SRAM write
- sram_addr_o out clog2(NumWords) word address
- sram_be_o out DataWidth/8 byte enables
- sram_wdata_o out DataWidth write data
- sram_rdata_i in DataWidth read data, valid one cycle after sram_req_o
- busy_o out 1 any transaction outstanding

Function
REQ-008 SHALL compute the word index as obi_addr_i[AddrWidth-1:clog2(DataWidth/8)]; sram_addr_o SHALL be its low clog2(NumWords) bits.
REQ-009 SHALL flag a request as out-of-range when the word index is >= NumWords.
REQ-010 SHALL keep credit count C = pending-stage occupancy (0/1) + FIFO fill; obi_gnt_o = obi_req_i AND (C < RspDepth); obi_gnt_o SHALL NOT depend combinationally on obi_rready_i.
REQ-011 On a grant in cycle T with an in-range request, SHALL assert sram_req_o in T with sram_we_o/be/wdata/addr driven from the OBI inputs; sram_req_o SHALL be 0 otherwise, including for out-of-range grants.
REQ-012 In T+1, SHALL push {rdata, rid, err} into the response FIFO; rdata SHALL be sram_rdata_i for reads and 0 for writes and for out-of-range requests; err SHALL be 1 only for out-of-range requests.
REQ-013 The FIFO SHALL be fall-through, so the earliest obi_rvalid_o is T+1 (one-cycle latency).
REQ-014 obi_rvalid_o = FIFO not empty; obi_rdata_o/rid/err SHALL be the FIFO head and SHALL hold stable while rvalid=1 and rready=0.
REQ-015 A pop occurs when rvalid AND rready; a same-cycle push and pop SHALL leave the fill unchanged.
REQ-016 Responses SHALL return strictly in grant order.
REQ-017 SHALL sustain one grant per cycle when obi_rready_i is held high and RspDepth >= 2.
REQ-018 When C == RspDepth, obi_gnt_o SHALL be 0 and sram_req_o SHALL be 0; the FIFO SHALL never overflow.
REQ-019 busy_o = (C != 0).
REQ-020 Read-after-write to the same address in back-to-back cycles SHALL return the new data (SRAM write-first ordering is preserved by issue order).

Reset
REQ-021 While rst_i is high, SHALL force obi_gnt_o=0, obi_rvalid_o=0, obi_rdata_o=0, obi_rid_o=0, obi_err_o=0, sram_req_o=0, busy_o=0, empty the FIFO, and clear the pending stage.
REQ-022 Reset asserted mid-transaction SHALL discard all outstanding responses; after deassertion, the first grant is possible in the next cycle.

Structure
REQ-023 Shared constants (the OBI error encoding and a DataWidth-to-offset-width function) SHALL reside in idma_pkg; no new package is created.
REQ-024 SHALL instantiate exactly one sub-module: fifo_v3 (common_cells) for the response FIFO, with FALL_THROUGH=1 and DEPTH=RspDepth; the pending stage and credit logic stay inline.

Verification
REQ-025 Write addr 0x10, be 0xF, data 0xDEADBEEF, then read 0x10 next cycle, rready=1 -> grants in T and T+1, rvalids in T+1 (rdata 0, err 0) and T+2 (rdata 0xDEADBEEF).
REQ-026 Read addr 4*NumWords -> gnt=1, sram_req_o=0, rvalid next cycle with err=1 and rdata 0.
REQ-027 RspDepth=2, rready=0, 4 back-to-back reads -> exactly 2 grants, then gnt=0 with busy_o=1; after rready=1, responses drain in order with matching rid and grants resume.
REQ-028 Continuous reads with rready=1 for 100 cycles -> 100 grants and 100 in-order responses, no stall cycles.
REQ-029 Assert rst_i with 2 responses queued -> rvalid=0 and busy_o=0 immediately; after release, a fresh read completes with 1-cycle latency.
REQ-030 Partial write be=0x2 data 0x0000AB00 over an existing word 0x11223344, then read -> 0x1122AB44.

Source files
------------

// File: rtl/idma_pkg.sv
// Shared iDMA constants: OBI response error encoding and byte-offset width helper.
package idma_pkg;

    localparam logic OBI_RSP_OKAY = 1'b0;
    localparam logic OBI_RSP_ERR  = 1'b1;

    // Number of byte-offset bits dropped from a byte address to get a word index.
    function automatic int unsigned obi_off_width(input int unsigned data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 0;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Parameterised FIFO with optional fall-through; an empty FIFO presents data_i on data_o when FALL_THROUGH=1.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_ptr, wr_ptr;
    logic [ADDR_DEPTH:0]   cnt;
    dtype                  mem [DEPTH];
    logic                  do_push, do_pop, bypass;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt == '0) & ~(FALL_THROUGH & push_i);
    assign usage_o = cnt[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && cnt == '0) ? data_i : mem[rd_ptr];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    // Push and pop on an empty fall-through FIFO pass straight through without storage.
    assign bypass  = FALL_THROUGH && (cnt == '0) && do_push && do_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (!bypass) begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !bypass && !flush_i) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/idma_obi_sram_bridge.sv
// OBI slave to single-port SRAM bridge: one-cycle latency, credit-limited outstanding
// responses held in a fall-through FIFO so grants never depend on rready.
module idma_obi_sram_bridge
    import idma_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned RspDepth  = 2,
    localparam int unsigned SramAw   = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   obi_req_i,
    input  logic [AddrWidth-1:0]   obi_addr_i,
    input  logic                   obi_we_i,
    input  logic [DataWidth/8-1:0] obi_be_i,
    input  logic [DataWidth-1:0]   obi_wdata_i,
    input  logic [IdWidth-1:0]     obi_aid_i,
    output logic                   obi_gnt_o,
    output logic                   obi_rvalid_o,
    input  logic                   obi_rready_i,
    output logic [DataWidth-1:0]   obi_rdata_o,
    output logic [IdWidth-1:0]     obi_rid_o,
    output logic                   obi_err_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [SramAw-1:0]      sram_addr_o,
    output logic [DataWidth/8-1:0] sram_be_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    input  logic [DataWidth-1:0]   sram_rdata_i,
    output logic                   busy_o
);

    localparam int unsigned OffW   = obi_off_width(DataWidth);
    localparam int unsigned CntW   = $clog2(RspDepth + 1) + 1;
    localparam int unsigned FifoAw = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } rsp_t;

    logic [AddrWidth-1:0] word_idx;
    logic                 oor;
    logic                 pend_vld, pend_we, pend_err;
    logic [IdWidth-1:0]   pend_rid;
    logic [CntW-1:0]      fill, credit;
    logic                 fifo_full, fifo_empty, fifo_pop, fifo_rst_n;
    logic [FifoAw-1:0]    fifo_usage;
    rsp_t                 push_rsp, head_rsp;

    assign word_idx = obi_addr_i >> OffW;
    assign oor      = (word_idx >= AddrWidth'(NumWords));

    // Credit covers the access in flight plus everything already queued.
    assign fill      = fifo_full ? CntW'(RspDepth) : CntW'(fifo_usage);
    assign credit    = fill + CntW'(pend_vld);
    assign obi_gnt_o = obi_req_i & ~rst_i & (credit < CntW'(RspDepth));
    assign busy_o    = (credit != '0);

    assign sram_req_o   = obi_gnt_o & ~oor;
    assign sram_we_o    = obi_we_i;
    assign sram_addr_o  = word_idx[SramAw-1:0];
    assign sram_be_o    = obi_be_i;
    assign sram_wdata_o = obi_wdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_vld <= 1'b0;
            pend_we  <= 1'b0;
            pend_err <= 1'b0;
            pend_rid <= '0;
        end else begin
            pend_vld <= obi_gnt_o;
            pend_we  <= obi_we_i;
            pend_err <= oor;
            pend_rid <= obi_aid_i;
        end
    end

    // Writes and out-of-range accesses return zero data.
    assign push_rsp.rdata = (pend_we | pend_err) ? '0 : sram_rdata_i;
    assign push_rsp.rid   = pend_rid;
    assign push_rsp.err   = pend_err ? OBI_RSP_ERR : OBI_RSP_OKAY;

    assign fifo_rst_n = ~rst_i;
    assign fifo_pop   = obi_rvalid_o & obi_rready_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b1),
        .DATA_WIDTH   ($bits(rsp_t)),
        .DEPTH        (RspDepth),
        .dtype        (rsp_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (fifo_rst_n),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (push_rsp),
        .push_i  (pend_vld),
        .data_o  (head_rsp),
        .pop_i   (fifo_pop)
    );

    assign obi_rvalid_o = ~fifo_empty;
    assign obi_rdata_o  = obi_rvalid_o ? head_rsp.rdata : '0;
    assign obi_rid_o    = obi_rvalid_o ? head_rsp.rid   : '0;
    assign obi_err_o    = obi_rvalid_o ? head_rsp.err   : 1'b0;

endmodule

// File: tb/tb_idma_obi_sram_bridge.sv
// Scoreboard bench for idma_obi_sram_bridge with a behavioural SRAM and reference memory.
module tb_idma_obi_sram_bridge;

    localparam int DW = 32, AW = 32, IW = 2, NW = 1024, RD = 2;
    localparam int SAW = $clog2(NW);

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic [IW-1:0] rid;
        logic          err;
    } rsp_t;

    logic            clk = 1'b0, rst = 1'b1;
    logic            obi_req, obi_we, obi_gnt, obi_rvalid, obi_rready, obi_err;
    logic [AW-1:0]   obi_addr;
    logic [DW/8-1:0] obi_be, sram_be;
    logic [DW-1:0]   obi_wdata, obi_rdata, sram_wdata, sram_rdata;
    logic [IW-1:0]   obi_aid, obi_rid;
    logic            sram_req, sram_we, busy;
    logic [SAW-1:0]  sram_addr;

    logic [DW-1:0] sram_mem [NW];
    logic [DW-1:0] ref_mem  [NW];
    rsp_t          sb_q [$];
    int            n_cmp = 0, n_err = 0, n_rsp = 0;
    logic [DW-1:0] last_rdata = '0;

    idma_obi_sram_bridge #(
        .DataWidth (DW), .AddrWidth (AW), .IdWidth (IW), .NumWords (NW), .RspDepth (RD)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .obi_req_i (obi_req), .obi_addr_i (obi_addr), .obi_we_i (obi_we), .obi_be_i (obi_be),
        .obi_wdata_i (obi_wdata), .obi_aid_i (obi_aid), .obi_gnt_o (obi_gnt),
        .obi_rvalid_o (obi_rvalid), .obi_rready_i (obi_rready), .obi_rdata_o (obi_rdata),
        .obi_rid_o (obi_rid), .obi_err_o (obi_err),
        .sram_req_o (sram_req), .sram_we_o (sram_we), .sram_addr_o (sram_addr),
        .sram_be_o (sram_be), .sram_wdata_o (sram_wdata), .sram_rdata_i (sram_rdata),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < DW/8; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pops/compares responses, checks head stability, pushes expectations on grants.
    initial begin
        logic held_vld;
        rsp_t held, cur, exp;
        int   widx;
        held_vld = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_vld = 1'b0;
            end else begin
                cur = '{obi_rdata, obi_rid, obi_err};
                if (obi_rvalid && held_vld) chk("hold", cur, held);
                if (obi_rvalid && obi_rready) begin
                    if (sb_q.size() == 0) chk("unexp_rsp", 1, 0);
                    else begin
                        exp = sb_q.pop_front();
                        chk("rdata", obi_rdata, exp.rdata);
                        chk("rid", obi_rid, exp.rid);
                        chk("err", obi_err, exp.err);
                        n_rsp++;
                        last_rdata = obi_rdata;
                    end
                end
                held_vld = obi_rvalid && !obi_rready;
                held = cur;
                if (obi_req && obi_gnt) begin
                    widx = int'(obi_addr / (DW/8));
                    exp.rid = obi_aid;
                    exp.err = (widx >= NW);
                    exp.rdata = '0;
                    if (widx < NW) begin
                        if (obi_we) begin
                            for (int b = 0; b < DW/8; b++)
                                if (obi_be[b]) ref_mem[widx][8*b +: 8] = obi_wdata[8*b +: 8];
                        end else exp.rdata = ref_mem[widx];
                    end
                    sb_q.push_back(exp);
                end
            end
        end
    end

    task automatic drive(input logic [AW-1:0] a, input logic we, input logic [DW/8-1:0] be,
                         input logic [DW-1:0] wd, input logic [IW-1:0] id);
        obi_req = 1'b1; obi_addr = a; obi_we = we; obi_be = be; obi_wdata = wd; obi_aid = id;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic we, input logic [DW/8-1:0] be,
                         input logic [DW-1:0] wd, input logic [IW-1:0] id);
        @(posedge clk); #1;
        drive(a, we, be, wd, id);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (obi_gnt) return;
            @(posedge clk); #1;
        end
        chk("issue_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        obi_req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int g, aid, stalls, n0;
        for (int i = 0; i < NW; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        sram_rdata = '0;
        obi_rready = 1'b1;
        drive(32'h10, 1'b0, '1, '0, '0);

        // Reset state with a request pending
        repeat (3) @(negedge clk);
        chk("rst_gnt", obi_gnt, 0);
        chk("rst_rvalid", obi_rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sram_req", sram_req, 0);
        chk("rst_rdata", obi_rdata, 0);
        chk("rst_rid", obi_rid, 0);
        chk("rst_err", obi_err, 0);

        // Write then back-to-back read of the same word
        @(posedge clk); #1;
        rst = 1'b0;
        drive(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 2'd0);
        @(negedge clk);
        chk("wr_gnt", obi_gnt, 1);
        chk("wr_sram_req", sram_req, 1);
        chk("wr_sram_we", sram_we, 1);
        chk("wr_sram_addr", sram_addr, 4);
        chk("wr_rvalid_t0", obi_rvalid, 0);
        @(posedge clk); #1;
        drive(32'h10, 1'b0, 4'hF, '0, 2'd1);
        @(negedge clk);
        chk("rd_gnt", obi_gnt, 1);
        chk("wr_rvalid_t1", obi_rvalid, 1);
        chk("wr_rdata", obi_rdata, 0);
        idle();
        @(negedge clk);
        chk("raw_rvalid", obi_rvalid, 1);
        chk("raw_rdata", obi_rdata, 32'hDEADBEEF);

        // Out-of-range read
        @(posedge clk); #1;
        drive(4*NW, 1'b0, 4'hF, '0, 2'd2);
        @(negedge clk);
        chk("oor_gnt", obi_gnt, 1);
        chk("oor_sram_req", sram_req, 0);
        idle();
        @(negedge clk);
        chk("oor_rvalid", obi_rvalid, 1);
        chk("oor_err", obi_err, 1);
        chk("oor_rdata", obi_rdata, 0);

        // Partial write merge
        issue(32'h20, 1'b1, 4'hF, 32'h11223344, 2'd0);
        issue(32'h20, 1'b1, 4'h2, 32'h0000AB00, 2'd1);
        issue(32'h20, 1'b0, 4'hF, '0, 2'd2);
        idle();
        wait_drain();
        chk("partial_merge", last_rdata, 32'h1122AB44);

        // Backpressure: credit limit stalls grants
        obi_rready = 1'b0;
        g = 0; aid = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(32'h40 + 4*aid, 1'b0, 4'hF, '0, IW'(aid));
            @(negedge clk);
            if (obi_gnt) begin g++; aid++; end
        end
        chk("bp_grants", g, 2);
        chk("bp_gnt_low", obi_gnt, 0);
        chk("bp_busy", busy, 1);
        for (int k = 0; k < 20 && aid < 4; k++) begin
            @(posedge clk); #1;
            obi_rready = 1'b1;
            drive(32'h40 + 4*aid, 1'b0, 4'hF, '0, IW'(aid));
            @(negedge clk);
            if (obi_gnt) aid++;
        end
        chk("bp_all_granted", aid, 4);
        idle();
        wait_drain();

        // Streaming reads: one grant per cycle
        n0 = n_rsp; stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            drive(AW'(4*i), 1'b0, 4'hF, '0, IW'(i));
            @(negedge clk);
            if (!obi_gnt) stalls++;
        end
        idle();
        wait_drain();
        chk("stream_stalls", stalls, 0);
        chk("stream_rsp", n_rsp - n0, 100);

        // Reset with two responses queued
        obi_rready = 1'b0;
        issue(32'h10, 1'b0, 4'hF, '0, 2'd0);
        issue(32'h20, 1'b0, 4'hF, '0, 2'd1);
        idle();
        @(negedge clk);
        chk("pre_rst_rvalid", obi_rvalid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", obi_rvalid, 0);
        chk("mid_rst_busy", busy, 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        obi_rready = 1'b1;
        drive(32'h10, 1'b0, 4'hF, '0, 2'd3);
        @(negedge clk);
        chk("post_rst_gnt", obi_gnt, 1);
        idle();
        @(negedge clk);
        chk("post_rst_rvalid", obi_rvalid, 1);
        chk("post_rst_rid", obi_rid, 3);
        wait_drain();
        chk("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
